// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared constants for the bit-serial subtractor controller
package sub_pkg;

  localparam int SUB_WIDTH = 8;

  // 2'd3 is unused; the controller treats it as a return to idle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - start/done operand and result bundle of serial_sub_ctrl
interface serial_sub_ctrl_if #(
  parameter int WIDTH = sub_pkg::SUB_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, borrow_out
  );

endinterface

// File: rtl/full_sub_gate.sv
// rtl/full_sub_gate.sv - combinational 1-bit full subtractor cell
module full_sub_gate (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - LSB-first bit-serial a - b - bin using one full_sub_gate
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_sub_ctrl_if.slave sif
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             borrow_reg;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;
  logic             cell_diff;
  logic             cell_borrow;

  full_sub_gate u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow_reg),
    .diff (cell_diff),
    .bout (cell_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      r_sh         <= '0;
      cnt          <= '0;
      borrow_reg   <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sif.start) begin
            a_sh       <= sif.a;
            b_sh       <= sif.b;
            borrow_reg <= sif.bin;
            cnt        <= '0;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sh       <= a_sh >> 1;
          b_sh       <= b_sh >> 1;
          r_sh       <= {cell_diff, r_sh[WIDTH-1:1]};
          borrow_reg <= cell_borrow;
          if (cnt == LAST) begin
            // Publish the completed word from the final cell output on the edge entering DONE
            diff_q       <= {cell_diff, r_sh[WIDTH-1:1]};
            borrow_out_q <= cell_borrow;
            cnt          <= '0;
            state        <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sif.ready      = (state == ST_IDLE);
  assign sif.busy       = (state == ST_SHIFT);
  assign sif.done       = (state == ST_DONE);
  assign sif.diff       = diff_q;
  assign sif.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed self-checking bench for serial_sub_ctrl
module tb_serial_sub_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
  serial_sub_ctrl_if #(.WIDTH(4)) if4 ();

  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .sif(if8.slave));
  serial_sub_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .sif(if4.slave));

  // Runs one operation on the selected instance; edges counts the accept edge plus shift edges
  task automatic do_op(input bit sel4, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output int edges, output bit tmo);
    @(negedge clk);
    if (sel4) begin
      if4.a = a[3:0]; if4.b = b[3:0]; if4.bin = bin; if4.start = 1'b1;
    end else begin
      if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1;
    end
    @(posedge clk);
    edges = 1;
    tmo   = 1'b1;
    d     = '0;
    bo    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if4.start = 1'b0;
      if8.start = 1'b0;
      if (sel4 ? if4.done : if8.done) begin
        d   = sel4 ? {4'h0, if4.diff} : if8.diff;
        bo  = sel4 ? if4.borrow_out : if8.borrow_out;
        tmo = 1'b0;
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({if8.ready, if8.busy, if8.done, if8.borrow_out} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got=%b want=1000", {if8.ready, if8.busy, if8.done, if8.borrow_out});
    end
    checks++;
    if (if8.diff !== 8'd0) begin
      errors++; $display("FAIL reset_diff got=%0d want=0", if8.diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo; int e; bit t;
    do_op(1'b0, 8'd200, 8'd55, 1'b0, d, bo, e, t);
    checks++;
    if (t) begin errors++; $display("FAIL basic_timeout got=no done want=done"); end
    checks++;
    if (e !== 9) begin errors++; $display("FAIL basic_latency got=%0d want=9", e); end
    checks++;
    if ({bo, d} !== {1'b0, 8'd145}) begin errors++; $display("FAIL basic_result got=%0d/%0d want=0/145", bo, d); end
    @(negedge clk);
    checks++;
    if ({if8.ready, if8.done, if8.diff} !== {1'b1, 1'b0, 8'd145}) begin
      errors++; $display("FAIL basic_after got=r%b d%b %0d want=r1 d0 145", if8.ready, if8.done, if8.diff);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'd5,  8'd0,  8'd128, 8'd255};
    logic [7:0] vb [4] = '{8'd10, 8'd0,  8'd1,   8'd255};
    logic       vc [4] = '{1'b0,  1'b1,  1'b0,   1'b1};
    logic [7:0] vd [4] = '{8'd251, 8'd255, 8'd127, 8'd255};
    logic       vo [4] = '{1'b1,  1'b1,  1'b0,   1'b1};
    logic [7:0] d; logic bo; int e; bit t;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, va[i], vb[i], vc[i], d, bo, e, t);
      checks++;
      if (t || {bo, d} !== {vo[i], vd[i]}) begin
        errors++; $display("FAIL vector%0d got=%0d/%0d tmo=%0d want=%0d/%0d", i, bo, d, t, vo[i], vd[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    logic [7:0] seen = '0;
    @(negedge clk);
    if8.a = 8'd100; if8.b = 8'd30; if8.bin = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    checks++;
    if (if8.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b want=1", if8.busy); end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 3) begin if8.a = 8'd1; if8.b = 8'd1; if8.start = 1'b1; end
      if (i == 4) if8.start = 1'b0;
      if (if8.done) begin ndone++; seen = if8.diff; end
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
    checks++;
    if (seen !== 8'd70 || if8.diff !== 8'd70) begin
      errors++; $display("FAIL ignore_result got=%0d held=%0d want=70", seen, if8.diff);
    end
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    logic [7:0] d; logic bo; int e; bit t;
    @(negedge clk);
    if8.a = 8'd200; if8.b = 8'd55; if8.bin = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.ready, if8.busy, if8.done, if8.borrow_out, if8.diff} !== {4'b1000, 8'd0}) begin
      errors++; $display("FAIL async_reset got=r%b b%b d%b bo%b %0d want=r1 b0 d0 bo0 0",
                         if8.ready, if8.busy, if8.done, if8.borrow_out, if8.diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL async_no_done got=%0d want=0", ndone); end
    do_op(1'b0, 8'd9, 8'd3, 1'b0, d, bo, e, t);
    checks++;
    if (t || {bo, d} !== {1'b0, 8'd6} || e !== 9) begin
      errors++; $display("FAIL async_recover got=%0d/%0d edges=%0d want=0/6 edges=9", bo, d, e);
    end
  endtask

  task automatic test_back_to_back();
    int at [3];
    int n = 0;
    bit bad = 1'b0;
    @(negedge clk);
    if8.a = 8'd50; if8.b = 8'd20; if8.bin = 1'b0; if8.start = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (if8.done) begin
        at[n] = c;
        n++;
        if (if8.diff !== 8'd30 || if8.borrow_out !== 1'b0 || if8.ready !== 1'b0) bad = 1'b1;
      end
    end
    if8.start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_count got=%0d want=3", n);
    end else begin
      checks++;
      if (at[0] !== 8 || at[1] - at[0] !== 10 || at[2] - at[1] !== 10) begin
        errors++; $display("FAIL b2b_period got=%0d,%0d,%0d want=8,18,28", at[0], at[1], at[2]);
      end
    end
    checks++;
    if (bad) begin errors++; $display("FAIL b2b_result got=wrong diff/flags at done want=30/0"); end
  endtask

  task automatic test_exhaustive4();
    logic [7:0] d; logic bo; int e; bit t;
    int r;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          do_op(1'b1, 8'(a), 8'(b), 1'(c), d, bo, e, t);
          r = a - b - c;
          checks++;
          if (t || e !== 5 || {bo, d[3:0]} !== {(r < 0), 4'(r)}) begin
            errors++; $display("FAIL exh4 a=%0d b=%0d bin=%0d got=%0d/%0d edges=%0d want=%0d/%0d edges=5",
                               a, b, c, bo, d[3:0], e, (r < 0), 4'(r));
          end
        end
  endtask

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_exhaustive4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
